// File: rtl/line_buf_sched.sv
// rtl/line_buf_sched.sv - line buffer ring scheduler: write strobes, ring rotation, window valid
module line_buf_sched #(
  parameter int NUM_LINES = 4,
  parameter int PTR_W     = 3,
  parameter int ADDR_W    = 10,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 line_end,
  input  logic                 pix_valid,
  input  logic                 filt_req,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [NUM_LINES-1:0] wr_sel,
  output logic [PTR_W-1:0]     rd_ptr,
  output logic                 shift_en,
  output logic                 win_valid,
  output logic                 filt_en,
  output logic [12:0]          line_cnt,
  output logic                 ovf_err
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0]    COL_LAST = ADDR_W'(H_ACTIVE - 1);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(NUM_LINES - 1);
  localparam logic [12:0]          CNT_MAX  = 13'(V_ACTIVE);
  localparam logic [12:0]          CNT_RUN  = 13'(NUM_LINES);
  localparam logic [NUM_LINES-1:0] SEL_ONE  = NUM_LINES'(1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      col_q, col_d;
  logic                   full_q, full_d;      // column H_ACTIVE-1 already consumed this line
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [12:0]            line_cnt_q, line_cnt_d;
  logic                   filt_en_q, filt_en_d;
  logic                   ovf_q, ovf_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [NUM_LINES-1:0]   wr_sel_q, wr_sel_d;
  logic                   shift_en_q, shift_en_d;
  logic                   win_valid_q, win_valid_d;

  // frame_start restarts the frame in the same cycle, so a coincident pixel
  // lands at column 0 / buffer 0 and a coincident line_end is dropped.
  logic                   in_line;
  logic [ADDR_W-1:0]      col_eff;
  logic                   full_eff;
  logic [PTR_W-1:0]       ptr_eff;
  logic                   pix_acc, pix_ovf, le_acc;
  logic [12:0]            cnt_inc;
  logic [PTR_W-1:0]       ptr_inc;

  assign in_line  = (state_q == FILL) || (state_q == RUN);
  assign col_eff  = frame_start ? '0 : col_q;
  assign full_eff = frame_start ? 1'b0 : full_q;
  assign ptr_eff  = frame_start ? '0 : wr_ptr_q;
  assign pix_acc  = pix_valid && (in_line || frame_start) && !full_eff;
  assign pix_ovf  = pix_valid && (in_line || frame_start) && full_eff;
  assign le_acc   = line_end && in_line && !frame_start;
  assign cnt_inc  = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + 13'd1;
  assign ptr_inc  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: frame_start always restarts filling; line_end advances FILL->RUN->DONE
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = FILL;
    end else if (le_acc) begin
      if (cnt_inc == CNT_MAX)      state_d = DONE;
      else if (cnt_inc >= CNT_RUN) state_d = RUN;
    end
  end

  // output/datapath next values for the registered outputs and ring counters
  always_comb begin
    col_d       = col_eff;
    full_d      = full_eff;
    wr_ptr_d    = ptr_eff;
    line_cnt_d  = frame_start ? 13'd0 : line_cnt_q;
    filt_en_d   = frame_start ? filt_req : filt_en_q;
    ovf_d       = frame_start ? 1'b0 : ovf_q;
    wr_en_d     = pix_acc;
    wr_addr_d   = frame_start ? '0 : wr_addr_q;
    wr_sel_d    = '0;
    win_valid_d = pix_acc && (state_q == RUN) && !frame_start;
    shift_en_d  = le_acc;
    if (pix_acc) begin
      wr_addr_d = col_eff;
      wr_sel_d  = SEL_ONE << ptr_eff;
      if (col_eff == COL_LAST) full_d = 1'b1;
      else                     col_d  = col_eff + ADDR_W'(1);
    end
    if (pix_ovf) ovf_d = 1'b1;
    // rotation applies after any pixel written in the same cycle
    if (le_acc) begin
      col_d      = '0;
      full_d     = 1'b0;
      wr_ptr_d   = ptr_inc;
      line_cnt_d = cnt_inc;
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      full_q      <= 1'b0;
      wr_ptr_q    <= '0;
      line_cnt_q  <= '0;
      filt_en_q   <= 1'b0;
      ovf_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_sel_q    <= '0;
      shift_en_q  <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      line_cnt_q  <= line_cnt_d;
      filt_en_q   <= filt_en_d;
      ovf_q       <= ovf_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_sel_q    <= wr_sel_d;
      shift_en_q  <= shift_en_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_sel    = wr_sel_q;
  assign rd_ptr    = wr_ptr_q;   // oldest stored line is the one being overwritten
  assign shift_en  = shift_en_q;
  assign win_valid = win_valid_q;
  assign filt_en   = filt_en_q;
  assign line_cnt  = line_cnt_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_line_buf_sched.sv
// tb/tb_line_buf_sched.sv - directed vector bench for line_buf_sched
module tb_line_buf_sched;

  logic        clk, rst, frame_start, line_end, pix_valid, filt_req;
  logic        wr_en, shift_en, win_valid, filt_en, ovf_err;
  logic [9:0]  wr_addr;
  logic [3:0]  wr_sel;
  logic [2:0]  rd_ptr;
  logic [12:0] line_cnt;

  int n_vec = 0;
  int n_err = 0;
  int shift_cnt = 0;

  line_buf_sched dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_end(line_end),
    .pix_valid(pix_valid), .filt_req(filt_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_sel(wr_sel), .rd_ptr(rd_ptr), .shift_en(shift_en), .win_valid(win_valid),
    .filt_en(filt_en), .line_cnt(line_cnt), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned rst, fs, le, pv, fr;
    int unsigned en, addr, sel, shift, win, filt, cnt, ovf, rd;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input int unsigned r, fs, le, pv, fr,
                              en, addr, sel, sh, win, filt, cnt, ovf, rd);
    vec_t v;
    v.rst = r; v.fs = fs; v.le = le; v.pv = pv; v.fr = fr;
    v.en = en; v.addr = addr; v.sel = sel; v.shift = sh; v.win = win;
    v.filt = filt; v.cnt = cnt; v.ovf = ovf; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (shift_en) shift_cnt++;
  endtask

  task automatic set_in(input logic fs, input logic le, input logic pv);
    frame_start = fs; line_end = le; pix_valid = pv;
  endtask

  initial begin
    int errs, wins, ens;
    rst = 1'b1; frame_start = 0; line_end = 0; pix_valid = 0; filt_req = 0;

    //        rst fs le pv fr | en addr sel sh win filt cnt ovf rd
    vt[0]  = mk(1, 0, 0, 0, 0,   0, 0,   0,  0, 0,  0,   0,  0,  0);
    vt[1]  = mk(0, 0, 0, 1, 0,   0, 0,   0,  0, 0,  0,   0,  0,  0);
    vt[2]  = mk(0, 1, 0, 1, 1,   1, 0,   1,  0, 0,  1,   0,  0,  0);
    vt[3]  = mk(0, 0, 0, 1, 0,   1, 1,   1,  0, 0,  1,   0,  0,  0);
    vt[4]  = mk(0, 0, 1, 1, 0,   1, 2,   1,  1, 0,  1,   1,  0,  1);
    vt[5]  = mk(0, 0, 0, 1, 0,   1, 0,   2,  0, 0,  1,   1,  0,  1);
    vt[6]  = mk(0, 1, 1, 0, 0,   0, 0,   0,  0, 0,  0,   0,  0,  0);
    vt[7]  = mk(0, 0, 1, 0, 0,   0, 0,   0,  1, 0,  0,   1,  0,  1);
    vt[8]  = mk(0, 0, 1, 0, 0,   0, 0,   0,  1, 0,  0,   2,  0,  2);
    vt[9]  = mk(0, 0, 1, 0, 0,   0, 0,   0,  1, 0,  0,   3,  0,  3);
    vt[10] = mk(0, 0, 1, 0, 0,   0, 0,   0,  1, 0,  0,   4,  0,  0);
    vt[11] = mk(0, 0, 0, 1, 0,   1, 0,   1,  0, 1,  0,   4,  0,  0);
    vt[12] = mk(0, 0, 1, 1, 0,   1, 1,   1,  1, 1,  0,   5,  0,  1);
    vt[13] = mk(0, 1, 0, 1, 1,   1, 0,   1,  0, 0,  1,   0,  0,  0);

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst[0]; frame_start = vt[i].fs[0]; line_end = vt[i].le[0];
      pix_valid = vt[i].pv[0]; filt_req = vt[i].fr[0];
      step();
      check($sformatf("row%0d.wr_en", i),     32'(wr_en),     vt[i].en);
      check($sformatf("row%0d.wr_addr", i),   32'(wr_addr),   vt[i].addr);
      check($sformatf("row%0d.wr_sel", i),    32'(wr_sel),    vt[i].sel);
      check($sformatf("row%0d.shift_en", i),  32'(shift_en),  vt[i].shift);
      check($sformatf("row%0d.win_valid", i), 32'(win_valid), vt[i].win);
      check($sformatf("row%0d.filt_en", i),   32'(filt_en),   vt[i].filt);
      check($sformatf("row%0d.line_cnt", i),  32'(line_cnt),  vt[i].cnt);
      check($sformatf("row%0d.ovf_err", i),   32'(ovf_err),   vt[i].ovf);
      check($sformatf("row%0d.rd_ptr", i),    32'(rd_ptr),    vt[i].rd);
    end

    // async reset mid-line while a write is on the outputs
    set_in(0, 0, 1); filt_req = 0;
    step();
    check("pre_rst.wr_en", 32'(wr_en), 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst.wr_en", 32'(wr_en), 0);
    check("async_rst.wr_addr", 32'(wr_addr), 0);
    check("async_rst.wr_sel", 32'(wr_sel), 0);
    check("async_rst.filt_en", 32'(filt_en), 0);
    step();
    rst = 1'b0;
    ens = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wr_en) ens++;
    end
    check("idle_no_write", 32'(ens), 0);

    // fill then run: 5 full lines, wr_sel / rd_ptr rotate around the ring
    shift_cnt = 0;
    set_in(1, 0, 0); step();
    for (int l = 0; l < 5; l++) begin
      errs = 0; wins = 0;
      for (int c = 0; c < 640; c++) begin
        set_in(0, 0, 1); step();
        if (wr_en !== 1'b1 || wr_addr !== 10'(c) || wr_sel !== 4'(1 << (l % 4))
            || rd_ptr !== 3'(l % 4)) errs++;
        if (win_valid) wins++;
      end
      check($sformatf("line%0d.pix", l), 32'(errs), 0);
      check($sformatf("line%0d.win", l), 32'(wins), (l == 4) ? 640 : 0);
      set_in(0, 1, 0); step();
      check($sformatf("line%0d.cnt", l), 32'(line_cnt), 32'(l + 1));
    end
    set_in(0, 0, 0); step();
    check("shift_pulses", 32'(shift_cnt), 5);

    // overrun: 641 pixels, the last is dropped and flagged
    errs = 0;
    for (int c = 0; c < 640; c++) begin
      set_in(0, 0, 1); step();
      if (wr_en !== 1'b1 || wr_addr !== 10'(c)) errs++;
    end
    check("ovr.pix", 32'(errs), 0);
    check("ovr.ovf_before", 32'(ovf_err), 0);
    set_in(0, 0, 1); step();
    check("ovr.wr_en", 32'(wr_en), 0);
    check("ovr.wr_addr", 32'(wr_addr), 639);
    check("ovr.ovf", 32'(ovf_err), 1);
    set_in(0, 1, 0); step();
    set_in(0, 0, 1); step();
    check("ovr.next_addr", 32'(wr_addr), 0);
    check("ovr.sticky", 32'(ovf_err), 1);
    set_in(0, 1, 0); step();
    set_in(1, 0, 0); filt_req = 0; step();
    check("ovr.cleared", 32'(ovf_err), 0);

    // filter latch and frame_start/line_end collision
    for (int i = 0; i < 100; i++) begin set_in(0, 1, 0); step(); end
    filt_req = 1;
    for (int i = 0; i < 101; i++) begin set_in(0, 1, 0); step(); end
    check("flt.hold", 32'(filt_en), 0);
    check("flt.cnt", 32'(line_cnt), 201);
    check("flt.rd", 32'(rd_ptr), 1);
    set_in(1, 1, 0); step();
    check("col.cnt", 32'(line_cnt), 0);
    check("col.rd", 32'(rd_ptr), 0);
    check("col.shift", 32'(shift_en), 0);
    check("col.filt", 32'(filt_en), 1);
    set_in(0, 0, 1); step();
    check("col.fill_wr", 32'(wr_en), 1);
    check("col.fill_win", 32'(win_valid), 0);
    for (int i = 0; i < 4; i++) begin set_in(0, 1, 0); step(); end
    set_in(0, 0, 1); step();
    check("run.win", 32'(win_valid), 1);
    for (int i = 0; i < 476; i++) begin set_in(0, 1, 0); step(); end
    check("done.cnt", 32'(line_cnt), 480);
    set_in(0, 0, 1); step();
    check("done.no_wr", 32'(wr_en), 0);
    set_in(0, 1, 0); step();
    check("done.sat", 32'(line_cnt), 480);
    check("done.no_shift", 32'(shift_en), 0);
    set_in(0, 0, 0); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
